// File: rtl/clock_mode_ctrl_if.sv
// Signal bundle between the debounce/pulse front end and the clock mode controller.
// The master side drives the user/tick inputs; the slave side is the controller.
interface clock_mode_ctrl_if #(
    parameter int NUM_FIELDS = 2,
    parameter int SEL_W      = 1
);
    logic                  adj;
    logic [SEL_W-1:0]      sel;
    logic                  pause_tog;
    logic                  tick_slow;
    logic                  tick_fast;
    logic                  use_slow;
    logic                  use_fast;
    logic [NUM_FIELDS-1:0] field_sel;
    logic                  blink_enable;
    logic                  count_enable;
    logic                  adj_inc;
    logic [1:0]            mode;

    modport master (
        output adj, sel, pause_tog, tick_slow, tick_fast,
        input  use_slow, use_fast, field_sel, blink_enable, count_enable, adj_inc, mode
    );

    modport slave (
        input  adj, sel, pause_tog, tick_slow, tick_fast,
        output use_slow, use_fast, field_sel, blink_enable, count_enable, adj_inc, mode
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Run/pause/adjust controller for the clock datapath with N adjustable fields,
// an adjust inactivity timeout (LOCK) and a post-adjust settle window.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | free-running count on tick_slow (gated by settle window)
// PAUSE | count held, tick_slow selected
// ADJ   | field adjust: fast tick, blink, per-field increment pulses
// LOCK  | adjust timed out; waits for adj to drop before leaving
module clock_mode_ctrl #(
    parameter int NUM_FIELDS    = 2,
    parameter int SEL_W         = 1,
    parameter int ADJ_TIMEOUT   = 30,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    clock_mode_ctrl_if.slave bus
);

    localparam int TMO_W = (ADJ_TIMEOUT   > 0) ? $clog2(ADJ_TIMEOUT + 1)   : 1;
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_FIELDS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = (ADJ_TIMEOUT > 0) ? TMO_W'(ADJ_TIMEOUT - 1) : '0;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_ADJ   = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    state_t           state;
    logic             resume_pause;
    logic [SEL_W-1:0] field;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SET_W-1:0] settle_cnt;

    logic [SEL_W-1:0] sel_c;
    logic             field_chg;
    logic             tmo_hit;

    // Clamp out-of-range field indices and detect timeout expiry.
    always_comb begin
        sel_c     = (bus.sel > SEL_MAX) ? SEL_MAX : bus.sel;
        field_chg = (sel_c != field);
        // A field change in the same cycle as tick_slow counts as activity, so it cannot time out.
        tmo_hit   = (ADJ_TIMEOUT != 0) && !field_chg && bus.tick_slow && (tmo_cnt == TMO_LAST);
    end

    // Mode FSM with the timeout and settle counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            resume_pause <= 1'b0;
            field        <= '0;
            tmo_cnt      <= '0;
            settle_cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (settle_cnt != '0)
                        settle_cnt <= settle_cnt - SET_W'(1);
                    if (bus.pause_tog) begin
                        state        <= ST_PAUSE;
                        resume_pause <= 1'b1;
                        settle_cnt   <= '0;
                    end else if (bus.adj) begin
                        state        <= ST_ADJ;
                        resume_pause <= 1'b0;
                        field        <= sel_c;
                        tmo_cnt      <= '0;
                    end
                end
                ST_PAUSE: begin
                    // Leaving PAUSE directly resumes counting with no settle window.
                    if (bus.pause_tog) begin
                        state        <= ST_RUN;
                        resume_pause <= 1'b0;
                    end else if (bus.adj) begin
                        state        <= ST_ADJ;
                        resume_pause <= 1'b1;
                        field        <= sel_c;
                        tmo_cnt      <= '0;
                    end
                end
                ST_ADJ: begin
                    field <= sel_c;
                    if (bus.pause_tog)
                        resume_pause <= ~resume_pause;
                    if (field_chg)
                        tmo_cnt <= '0;
                    else if (bus.tick_slow)
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (!bus.adj) begin
                        if (resume_pause) begin
                            state <= ST_PAUSE;
                        end else begin
                            state      <= ST_RUN;
                            settle_cnt <= SETTLE_LD;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (bus.pause_tog)
                        resume_pause <= ~resume_pause;
                    if (!bus.adj) begin
                        if (resume_pause) begin
                            state <= ST_PAUSE;
                        end else begin
                            state      <= ST_RUN;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Output decode from the registered state and the live inputs.
    always_comb begin
        bus.use_slow     = 1'b1;
        bus.use_fast     = 1'b0;
        bus.field_sel    = '0;
        bus.blink_enable = 1'b0;
        bus.count_enable = 1'b0;
        bus.adj_inc      = 1'b0;
        bus.mode         = state;
        case (state)
            ST_RUN: begin
                bus.count_enable = ~bus.adj & (settle_cnt == '0);
            end
            ST_ADJ: begin
                bus.use_slow     = 1'b0;
                bus.use_fast     = 1'b1;
                bus.blink_enable = 1'b1;
                bus.field_sel    = NUM_FIELDS'(1) << field;
                bus.adj_inc      = bus.tick_fast & bus.adj;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Generalised run/pause/adjust controller for the clock datapath, supporting NUM_FIELDS adjustable fields instead of a fixed minutes/seconds pair. It selects the tick rate, drives a one-hot field-select bus, and issues per-field increment pulses while adjusting. It also adds an adjust inactivity timeout with a lockout state, and a post-adjust settle window that suppresses counting. It sits between the debounce/pulse logic and the counter/display datapath.

Parameters:
NUM_FIELDS, 2, number of adjustable fields (>=2).
SEL_W, 1, width of sel; must satisfy 2**SEL_W >= NUM_FIELDS.
ADJ_TIMEOUT, 30, number of tick_slow pulses in ADJ with no field change before forced exit; 0 disables the timeout.
SETTLE_CYCLES, 4, clk cycles count_enable stays low after returning to RUN from ADJ or LOCK; 0 disables the settle window.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
adj  in  1  debounced adjust level
sel  in  SEL_W  debounced field index; values >= NUM_FIELDS clamp to NUM_FIELDS-1
pause_tog  in  1  one-cycle pause toggle pulse
tick_slow  in  1  one-cycle 1 Hz pulse
tick_fast  in  1  one-cycle 2 Hz pulse
use_slow  out  1  datapath uses tick_slow
use_fast  out  1  datapath uses tick_fast
field_sel  out  NUM_FIELDS  one-hot selected field while in ADJ, else 0
blink_enable  out  1  display blink while in ADJ
count_enable  out  1  free-running count permitted
adj_inc  out  1  increment pulse for the selected field
mode  out  2  status: 0 RUN, 1 PAUSE, 2 ADJ, 3 LOCK

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All registers clear immediately when rst is asserted.
- Registered state: state, resume_pause, field[SEL_W], tmo_cnt, settle_cnt.
- Reset values: state=RUN, resume_pause=0, field=0, tmo_cnt=0, settle_cnt=0.
- Output values during and after reset: use_slow=1, use_fast=0, field_sel=0, blink_enable=0, adj_inc=0, mode=0, count_enable=~adj.
- Outputs are combinational decodes of the registered state plus the listed inputs.
- RUN:
  - pause_tog takes priority and moves to PAUSE. It also sets resume_pause=1 and clears settle_cnt.
  - Otherwise adj moves to ADJ with resume_pause=0.
  - Outputs: use_slow=1; count_enable = ~adj & (settle_cnt==0).
- PAUSE:
  - pause_tog takes priority and moves to RUN with resume_pause=0. settle_cnt is not loaded on this transition.
  - Otherwise adj moves to ADJ with resume_pause=1.
  - Outputs: use_slow=1, count_enable=0.
- Entry into ADJ: field <= clamp(sel), tmo_cnt <= 0.
- ADJ:
  - Outputs: use_fast=1, blink_enable=1, count_enable=0, field_sel=onehot(field), adj_inc=tick_fast.
  - Each cycle, field <= clamp(sel). field_sel therefore follows sel with 1-cycle latency.
  - If clamp(sel) != field, tmo_cnt <= 0 (field change). Otherwise tmo_cnt increments on tick_slow.
  - A field change and a tick_slow in the same cycle resolve as a reset: tmo_cnt <= 0.
  - Exits have priority !adj > timeout:
    - adj=0: go to PAUSE if resume_pause=1, else to RUN.
    - ADJ_TIMEOUT!=0 and tmo_cnt==ADJ_TIMEOUT-1 with tick_slow: go to LOCK.
  - pause_tog toggles resume_pause.
  - adj_inc does not fire in the cycle adj drops.
- LOCK:
  - Outputs: use_slow=1, count_enable=0, blink_enable=0, field_sel=0, adj_inc=0.
  - Waits for adj=0, then goes to PAUSE if resume_pause=1, else to RUN.
  - pause_tog toggles resume_pause.
  - adj held high never re-enters ADJ from LOCK.
- Settle window:
  - Any ADJ->RUN or LOCK->RUN transition loads settle_cnt=SETTLE_CYCLES.
  - In RUN, settle_cnt decrements by 1 per cycle, saturating at 0.
  - With settle_cnt=N, count_enable stays low for N cycles after entering RUN.
- tmo_cnt width: $clog2(ADJ_TIMEOUT+1), minimum 1. settle_cnt width: $clog2(SETTLE_CYCLES+1), minimum 1.
- Simultaneous pause_tog and adj in RUN or PAUSE: the pause toggle wins; adj is re-evaluated on the next cycle.
- Asserting rst in any state forces RUN immediately. Any pending settle window or timeout is discarded.

Test Plan:
1. Reset release with adj=0 -> mode=0, count_enable=1, use_slow=1, field_sel=0.
2. NUM_FIELDS=3, SEL_W=2, in RUN: raise adj with sel=3 -> ADJ next cycle, field_sel=3'b100. Change sel to 0 -> field_sel=3'b001 one cycle later. Three tick_fast pulses -> three adj_inc pulses.
3. Enter ADJ from PAUSE, drop adj -> mode=1, count_enable=0. Enter ADJ from RUN, pulse pause_tog once, drop adj -> mode=1.
4. ADJ_TIMEOUT=3, adj held with sel constant, 3 tick_slow pulses -> mode=3 after the third, blink_enable=0, no further adj_inc. Drop adj -> mode=0, count_enable low for SETTLE_CYCLES=4 cycles, then 1.
5. ADJ_TIMEOUT=3, sel changes after 2 tick_slow pulses -> tmo_cnt resets to 0; 3 further tick_slow pulses are needed to reach LOCK.
6. pause_tog and adj asserted in the same cycle from RUN -> mode=1 (not ADJ). Assert rst mid-ADJ -> mode=0 asynchronously, field_sel=0.
